piso_serializer: RTL and testbench

Parallel-in, serial-out transmitter that turns one captured WIDTH-bit word into a framed bit stream, one bit per BIT_DIV clocks, MSB-first or LSB-first. It is the transmit end for the team's serial-in shift-register receivers. With BIT_DIV=1, a downstream serial-in register clocked on the same clk holds the complete word after WIDTH shifts when its shift direction matches msb_first (left-shift for MSB-first, right-shift for LSB-first). A valid/ready handshake on the parallel side lets a controller queue words.

---
 rtl/piso_serializer_pkg.sv | 25 ++
 rtl/piso_serializer_bit_timer.sv | 33 +++
 rtl/piso_serializer.sv | 117 +++++++++++
 tb/tb_piso_serializer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared types and constants for the PISO serializer.
// States, default geometry, output idle values and counter sizing.
package piso_serializer_pkg;

  localparam int WIDTH_DEF   = 4;
  localparam int BIT_DIV_DEF = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic READY_RST  = 1'b1;
  localparam logic SERIAL_RST = 1'b0;
  localparam logic FRAME_RST  = 1'b0;
  localparam logic STROBE_RST = 1'b0;
  localparam logic DONE_RST   = 1'b0;

  // Counter width for a 0..n-1 range; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_serializer_bit_timer.sv
// Per-bit divider: counts 0..BIT_DIV-1 while run is high.
// tick marks the last cycle of a bit, first marks its first cycle.
module bit_timer
  import piso_serializer_pkg::*;
#(
  parameter int BIT_DIV = BIT_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick,
  output logic first
);

  localparam int CW = cnt_w(BIT_DIV);
  localparam logic [CW-1:0] LAST = CW'(BIT_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick  = run && (cnt == LAST);
  assign first = run && (cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with valid/ready capture.
// Sends one framed word per handshake, MSB- or LSB-first.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int BIT_DIV = BIT_DIV_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  input  logic             msb_first,
  output logic             ready_out,
  output logic             serial_out,
  output logic             frame_out,
  output logic             bit_strobe,
  output logic             done_out
);

  localparam int BW = cnt_w(WIDTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] shreg;
  logic             msb_q;
  logic [BW-1:0]    bit_cnt;
  logic             run;
  logic             tick;
  logic             first;
  logic             accept;
  logic             last_bit;

  assign run      = (state == SHIFT);
  assign accept   = valid_in && ready_out;
  assign last_bit = tick && (bit_cnt == BIT_LAST);

  bit_timer #(
    .BIT_DIV (BIT_DIV)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .tick  (tick),
    .first (first)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = SHIFT;
      SHIFT:   if (last_bit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Register always moves toward whichever end feeds serial_out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      msb_q   <= 1'b0;
      bit_cnt <= '0;
    end else if (accept) begin
      shreg   <= data_in;
      msb_q   <= msb_first;
      bit_cnt <= '0;
    end else if (tick) begin
      if (msb_q) begin
        shreg <= {shreg[WIDTH-2:0], 1'b0};
      end else begin
        shreg <= {1'b0, shreg[WIDTH-1:1]};
      end
      if (last_bit) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    ready_out  = READY_RST;
    serial_out = SERIAL_RST;
    frame_out  = FRAME_RST;
    bit_strobe = STROBE_RST;
    done_out   = DONE_RST;
    unique case (state)
      IDLE: begin
        ready_out = 1'b1;
      end
      SHIFT: begin
        ready_out  = 1'b0;
        frame_out  = 1'b1;
        bit_strobe = first;
        serial_out = msb_q ? shreg[WIDTH-1] : shreg[0];
      end
      DONE: begin
        ready_out = 1'b0;
        done_out  = 1'b1;
      end
      default: begin
        ready_out = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: a 4-bit/div-1 and an 8-bit/div-3 instance
// checked cycle by cycle against a bit-order and timing reference model.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] data4 = '0;
  logic       valid4 = 1'b0;
  logic       msb4 = 1'b0;
  logic [7:0] data8 = '0;
  logic       valid8 = 1'b0;
  logic       msb8 = 1'b0;
  logic       ready4, ser4, frame4, strobe4, done4;
  logic       ready8, ser8, frame8, strobe8, done8;

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .BIT_DIV(1)) u4 (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data4),
    .valid_in   (valid4),
    .msb_first  (msb4),
    .ready_out  (ready4),
    .serial_out (ser4),
    .frame_out  (frame4),
    .bit_strobe (strobe4),
    .done_out   (done4)
  );

  piso_serializer #(.WIDTH(8), .BIT_DIV(3)) u8 (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data8),
    .valid_in   (valid8),
    .msb_first  (msb8),
    .ready_out  (ready8),
    .serial_out (ser8),
    .frame_out  (frame8),
    .bit_strobe (strobe8),
    .done_out   (done8)
  );

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {ready, frame, serial, strobe, done}
  function automatic logic [15:0] outs(input int d);
    if (d == 0) return {11'b0, ready4, frame4, ser4, strobe4, done4};
    return {11'b0, ready8, frame8, ser8, strobe8, done8};
  endfunction

  function automatic logic [15:0] vec(input logic r, input logic f,
                                      input logic s, input logic b,
                                      input logic dn);
    return {11'b0, r, f, s, b, dn};
  endfunction

  task automatic drive(input int d, input logic v, input logic [15:0] w,
                       input logic m);
    if (d == 0) begin
      valid4 = v;
      data4  = w[3:0];
      msb4   = m;
    end else begin
      valid8 = v;
      data8  = w[7:0];
      msb8   = m;
    end
  endtask

  // Sends one word and checks every cycle from E0 until ready returns.
  // With tog set, valid/data/msb keep changing while the word is in flight.
  task automatic send_word(input int d, input logic [15:0] w_in,
                           input logic m, input bit tog);
    int nb;
    int bd;
    logic [15:0] w;
    logic [15:0] mask;
    logic [15:0] rx;
    logic [15:0] s;
    logic b;
    nb = (d == 0) ? 4 : 8;
    bd = (d == 0) ? 1 : 3;
    mask = 16'((32'd1 << nb) - 1);
    w = w_in & mask;
    rx = '0;
    @(negedge clk);
    drive(d, 1'b1, w, m);
    check($sformatf("d%0d_ready_pre", d), outs(d), vec(1, 0, 0, 0, 0));
    @(posedge clk);
    for (int k = 0; k < nb * bd + 2; k++) begin
      @(negedge clk);
      if (tog && k < nb * bd)
        drive(d, 1'b1, 16'($urandom), 1'($urandom));
      else
        drive(d, 1'b0, 16'($urandom), 1'($urandom));
      if (k < nb * bd) begin
        b = m ? w[nb - 1 - k / bd] : w[k / bd];
        check($sformatf("d%0d_w%0h_k%0d", d, w, k), outs(d),
              vec(0, 1, b, (k % bd) == 0, 0));
        if ((k % bd) == bd - 1) begin
          s = outs(d) >> 2;
          s = s & 16'd1;
          if (m) rx = ((rx << 1) | s) & mask;
          else   rx = (rx >> 1) | (s << (nb - 1));
        end
      end else if (k == nb * bd) begin
        check($sformatf("d%0d_done", d), outs(d), vec(0, 0, 0, 0, 1));
      end else begin
        check($sformatf("d%0d_ready_post", d), outs(d),
              vec(1, 0, 0, 0, 0));
      end
    end
    check($sformatf("d%0d_rx_m%0d", d, m), rx, w);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    logic [15:0] exps [0:63];
    int hs[$];

    #1;
    check("rst_u4", outs(0), vec(1, 0, 0, 0, 0));
    check("rst_u8", outs(1), vec(1, 0, 0, 0, 0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    send_word(0, 16'b1011, 1'b1, 1'b0);
    send_word(0, 16'b1011, 1'b0, 1'b0);
    send_word(1, 16'hA5, 1'b1, 1'b0);
    send_word(0, 16'($urandom), 1'($urandom), 1'b1);
    send_word(1, 16'($urandom), 1'($urandom), 1'b1);

    for (int i = 0; i < 6; i++) begin
      send_word(0, 16'($urandom), 1'($urandom), 1'(i % 2));
      send_word(1, 16'($urandom), 1'($urandom), 1'(i % 2));
    end

    for (int t = 0; t < 64; t++) exps[t] = '0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      check($sformatf("b2b_ser_t%0d", t), {15'b0, ser4}, exps[t]);
      w = 16'($urandom) & 16'hF;
      drive(0, 1'b1, w, 1'b1);
      if (ready4) begin
        hs.push_back(t);
        for (int n = 0; n < 4; n++)
          if (t + 1 + n < 64) exps[t + 1 + n] = {15'b0, w[3 - n]};
      end
    end
    drive(0, 1'b0, 16'h0, 1'b0);
    check("b2b_count", 16'(hs.size()), 16'd7);
    for (int i = 1; i < hs.size(); i++)
      check($sformatf("b2b_period%0d", i), 16'(hs[i] - hs[i-1]), 16'd6);
    repeat (8) @(negedge clk);

    @(negedge clk);
    drive(0, 1'b1, 16'hF, 1'b1);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(0, 1'b0, 16'h0, 1'b0);
      check($sformatf("rst_mid_k%0d", k), outs(0), vec(0, 1, 1, 1, 0));
    end
    #2;
    reset = 1'b1;
    #1;
    check("rst_async", outs(0), vec(1, 0, 0, 0, 0));
    @(negedge clk);
    check("rst_hold", outs(0), vec(1, 0, 0, 0, 0));
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("rst_nodone%0d", k), outs(0), vec(1, 0, 0, 0, 0));
    end
    send_word(0, 16'b1001, 1'b1, 1'b0);
    send_word(0, 16'b0110, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
